// File: rtl/axi4_dual_master_read_arbiter_pkg.sv
// Shared definitions for the two-master AXI4 read arbiter: FSM encoding,
// AXI response codes and master index assignments.
package axi4_dual_master_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic MST_SERV = 1'b0;
  localparam logic MST_ALU  = 1'b1;

endpackage

// File: rtl/axi4_dual_master_read_arbiter_rr_grant_2.sv
// Two-requester round-robin picker; the pointer remembers the last owner so
// that on a tie the other master wins.
module rr_grant_2
  import axi4_dual_master_read_arbiter_pkg::*;
(
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       winner,
  output logic [1:0] pick
);

  logic last_q;

  // Reset as if the ALU master owned last, so SERV wins the first tie.
  always_ff @(posedge ACLK) begin
    if (!ARESETN)    last_q <= MST_ALU;
    else if (update) last_q <= winner;
  end

  always_comb begin
    pick = req;
    if (req == 2'b11) pick = (last_q == MST_ALU) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/axi4_dual_master_read_arbiter.sv
// Shares one AXI4 read path between the SERV and ALU masters, one burst at a
// time, and flags bursts whose RLAST position disagrees with ARLEN.
module axi4_dual_master_read_arbiter
  import axi4_dual_master_read_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [LEN_WIDTH-1:0]  s0_arlen,
  input  logic [ID_WIDTH-1:0]   s0_arid,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [LEN_WIDTH-1:0]  s1_arlen,
  input  logic [ID_WIDTH-1:0]   s1_arid,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [LEN_WIDTH-1:0]  m_arlen,
  output logic [ID_WIDTH:0]     m_arid,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  len_err
);

  arb_state_t           state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic [LEN_WIDTH-1:0] arlen_q, arlen_d;
  logic [LEN_WIDTH:0]   cnt_q, cnt_d;
  logic                 err_seen_q, err_seen_d;
  logic                 len_err_d;
  logic [1:0]           pick;
  logic                 rr_update;
  logic                 g;
  logic                 in_data;

  assign g       = grant_q[1];
  assign in_data = (state_q == ARB_DATA);
  assign grant   = grant_q;
  assign busy    = (state_q != ARB_IDLE);

  assign m_araddr = (g == MST_ALU) ? s1_araddr : s0_araddr;
  assign m_arlen  = (g == MST_ALU) ? s1_arlen  : s0_arlen;
  assign m_arid   = {g, (g == MST_ALU) ? s1_arid : s0_arid};

  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign s0_rresp = (in_data && g == MST_SERV) ? m_rresp : OKAY;
  assign s1_rresp = (in_data && g == MST_ALU)  ? m_rresp : OKAY;
  assign s0_rlast = in_data && (g == MST_SERV) && m_rlast;
  assign s1_rlast = in_data && (g == MST_ALU)  && m_rlast;

  rr_grant_2 u_rr (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .req     ({s1_arvalid, s0_arvalid}),
    .update  (rr_update),
    .winner  (g),
    .pick    (pick)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q    <= ARB_IDLE;
      grant_q    <= 2'b00;
      arlen_q    <= '0;
      cnt_q      <= '0;
      err_seen_q <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      arlen_q    <= arlen_d;
      cnt_q      <= cnt_d;
      err_seen_q <= err_seen_d;
      len_err    <= len_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    arlen_d    = arlen_q;
    cnt_d      = cnt_q;
    err_seen_d = err_seen_q;
    len_err_d  = 1'b0;
    rr_update  = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|pick) begin
          grant_d    = pick;
          arlen_d    = pick[1] ? s1_arlen : s0_arlen;
          cnt_d      = '0;
          err_seen_d = 1'b0;
          state_d    = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        m_arvalid = 1'b1;
        if (g == MST_ALU) s1_arready = m_arready;
        else              s0_arready = m_arready;
        if (m_arready) state_d = ARB_DATA;
      end
      ARB_DATA: begin
        m_rready  = (g == MST_ALU) ? s1_rready : s0_rready;
        s0_rvalid = m_rvalid && (g == MST_SERV);
        s1_rvalid = m_rvalid && (g == MST_ALU);
        if (m_rvalid && m_rready) begin
          cnt_d = cnt_q + 1'b1;
          // Only the first mismatch of a burst is reported.
          if (m_rlast) begin
            len_err_d = (cnt_q != {1'b0, arlen_q}) && !err_seen_q;
            rr_update = 1'b1;
            grant_d   = 2'b00;
            state_d   = ARB_IDLE;
          end else if ((cnt_q == {1'b0, arlen_q}) && !err_seen_q) begin
            len_err_d  = 1'b1;
            err_seen_d = 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_dual_master_read_arbiter.sv
// Self-checking bench for the dual-master read arbiter: a table of bursts,
// randomized bursts against a round-robin model, and reset-abort sequence.
module tb_axi4_dual_master_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] s0_araddr, s1_araddr, m_araddr;
  logic [7:0]  s0_arlen, s1_arlen, m_arlen;
  logic [3:0]  s0_arid, s1_arid;
  logic [4:0]  m_arid;
  logic        s0_arvalid, s1_arvalid, s0_arready, s1_arready;
  logic [31:0] s0_rdata, s1_rdata, m_rdata;
  logic [1:0]  s0_rresp, s1_rresp, m_rresp;
  logic        s0_rlast, s1_rlast, m_rlast;
  logic        s0_rvalid, s1_rvalid, m_rvalid;
  logic        s0_rready, s1_rready, m_rready;
  logic        m_arvalid, m_arready;
  logic [1:0]  grant;
  logic        busy, len_err;

  int checks   = 0;
  int failures = 0;
  int n_bursts = 0;
  int mdl_last;

  always #5 ACLK = ~ACLK;

  axi4_dual_master_read_arbiter dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arid(s0_arid),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arid(s1_arid),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant(grant), .busy(busy), .len_err(len_err)
  );

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] len;
    int         last;
    int         stall;
    bit         rnd;
    logic [1:0] g;
    int         errs;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (burst %0d)", name, act, exp, n_bursts);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, grant, 2'b00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_len_err"}, len_err, 1'b0);
    chk({tag, "_m_arvalid"}, m_arvalid, 1'b0);
    chk({tag, "_m_rready"}, m_rready, 1'b0);
    chk({tag, "_arready"}, {s0_arready, s1_arready}, 2'b00);
    chk({tag, "_rvalid"}, {s0_rvalid, s1_rvalid}, 2'b00);
  endtask

  // One complete burst: arbitration, optional AR stall, R beats with the
  // RLAST placed at beat index last_idx, and return to idle.
  task automatic do_burst(input logic v0, input logic v1, input logic [7:0] len,
                          input int last_idx, input int stall, input bit rnd,
                          input logic [1:0] exp_g, input int exp_errs);
    logic [31:0] a0, a1, d;
    logic [3:0]  i0, i1;
    logic [1:0]  rsp;
    logic        w, wrdy, hs, exp_le, rep;
    int          k, guard, errs;
    w = exp_g[1];
    chk("idle_busy", busy, 1'b0);
    chk("idle_grant", grant, 2'b00);
    a0 = (n_bursts == 0) ? 32'h4000_0010 : $urandom;
    a1 = $urandom;
    i0 = 4'($urandom);
    i1 = 4'($urandom);
    s0_araddr = a0; s1_araddr = a1; s0_arid = i0; s1_arid = i1;
    s0_arlen = (w == 1'b0) ? len : 8'($urandom);
    s1_arlen = (w == 1'b1) ? len : 8'($urandom);
    s0_arvalid = v0; s1_arvalid = v1;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    @(posedge ACLK); #1;
    chk("grant", grant, exp_g);
    chk("busy_addr", busy, 1'b1);
    for (int c = 0; c <= stall; c++) begin
      m_arready = (c == stall);
      #1;
      chk("m_arvalid", m_arvalid, 1'b1);
      chk("m_araddr", m_araddr, w ? a1 : a0);
      chk("m_arlen", m_arlen, len);
      chk("m_arid", m_arid, {w, w ? i1 : i0});
      chk("s0_arready", s0_arready, (w == 1'b0) && (c == stall));
      chk("s1_arready", s1_arready, (w == 1'b1) && (c == stall));
      @(posedge ACLK); #1;
    end
    if (w) s1_arvalid = 1'b0; else s0_arvalid = 1'b0;
    m_arready = 1'b0;
    k = 0; guard = 0; errs = 0; rep = 1'b0;
    while (k <= last_idx && guard < 3000) begin
      m_rvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = $urandom; rsp = 2'($urandom);
      m_rdata = d; m_rresp = rsp; m_rlast = (k == last_idx);
      s0_rready = (rnd || w) ? 1'($urandom) : 1'b1;
      s1_rready = (rnd || !w) ? 1'($urandom) : 1'b1;
      #1;
      wrdy = w ? s1_rready : s0_rready;
      chk("m_rready", m_rready, wrdy);
      chk("rvalid_win", w ? s1_rvalid : s0_rvalid, m_rvalid);
      chk("rvalid_lose", w ? s0_rvalid : s1_rvalid, 1'b0);
      chk("arready_data", {s0_arready, s1_arready, m_arvalid}, 3'b000);
      if (m_rvalid) begin
        chk("rdata", w ? s1_rdata : s0_rdata, d);
        chk("rresp", w ? s1_rresp : s0_rresp, rsp);
        chk("rlast", w ? s1_rlast : s0_rlast, m_rlast);
      end
      hs = m_rvalid && wrdy;
      exp_le = 1'b0;
      if (hs && !rep && ((k == int'(len) && k != last_idx) || (k == last_idx && k != int'(len)))) begin
        exp_le = 1'b1;
        rep = 1'b1;
      end
      @(posedge ACLK); #1;
      chk("len_err", len_err, exp_le);
      if (len_err) errs++;
      if (hs) k++;
      guard++;
    end
    chk("beat_timeout", k, last_idx + 1);
    m_rvalid = 1'b0; m_rlast = 1'b0;
    chk("end_busy", busy, 1'b0);
    chk("end_grant", grant, 2'b00);
    chk("len_err_count", errs, exp_errs);
    n_bursts++;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'd3,   3,   0, 1'b0, 2'b01, 0};
    tbl[1]  = '{1'b0, 1'b1, 8'd2,   2,   0, 1'b0, 2'b10, 0};
    tbl[2]  = '{1'b1, 1'b1, 8'd1,   1,   0, 1'b1, 2'b01, 0};
    tbl[3]  = '{1'b1, 1'b1, 8'd0,   0,   0, 1'b0, 2'b10, 0};
    tbl[4]  = '{1'b1, 1'b1, 8'd2,   2,   1, 1'b1, 2'b01, 0};
    tbl[5]  = '{1'b1, 1'b1, 8'd3,   3,   0, 1'b0, 2'b10, 0};
    tbl[6]  = '{1'b0, 1'b1, 8'd4,   4,   5, 1'b0, 2'b10, 0};
    tbl[7]  = '{1'b1, 1'b0, 8'd1,   2,   0, 1'b0, 2'b01, 1};
    tbl[8]  = '{1'b0, 1'b1, 8'd3,   1,   0, 1'b0, 2'b10, 1};
    tbl[9]  = '{1'b0, 1'b1, 8'd0,   0,   0, 1'b0, 2'b10, 0};
    tbl[10] = '{1'b1, 1'b1, 8'd2,   2,   0, 1'b1, 2'b01, 0};
    tbl[11] = '{1'b0, 1'b1, 8'hFF, 255,  0, 1'b1, 2'b10, 0};

    ARESETN = 1'b0;
    s0_araddr = '0; s1_araddr = '0; s0_arlen = '0; s1_arlen = '0;
    s0_arid = '0; s1_arid = '0; s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    s0_rready = 1'b0; s1_rready = 1'b0; m_arready = 1'b0;
    m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    chk_reset_outputs("rst");
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    chk_reset_outputs("idle");

    for (int i = 0; i < 12; i++)
      do_burst(tbl[i].v0, tbl[i].v1, tbl[i].len, tbl[i].last, tbl[i].stall,
               tbl[i].rnd, tbl[i].g, tbl[i].errs);
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;

    // Reset in the middle of a SERV burst aborts straight to idle.
    s0_araddr = 32'h1234_5678; s0_arlen = 8'd7; s0_arvalid = 1'b1;
    m_arready = 1'b1;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    s0_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b0; s0_rready = 1'b1;
    #1;
    chk("pre_rst_rvalid", s0_rvalid, 1'b1);
    @(posedge ACLK); #1;
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    chk_reset_outputs("abort");
    ARESETN = 1'b1;
    m_rvalid = 1'b0; m_arready = 1'b0;
    do_burst(1'b0, 1'b1, 8'd2, 2, 0, 1'b0, 2'b10, 0);
    mdl_last = 1;
    s1_arvalid = 1'b0;

    for (int n = 0; n < 30; n++) begin
      logic rv0, rv1;
      int   win, len_r, last_r;
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      if (!rv0 && !rv1) rv1 = 1'b1;
      if (rv0 && rv1) win = 1 - mdl_last;
      else            win = rv1 ? 1 : 0;
      len_r  = $urandom_range(0, 7);
      last_r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : len_r;
      do_burst(rv0, rv1, 8'(len_r), last_r, $urandom_range(0, 3), 1'b1,
               (win == 1) ? 2'b10 : 2'b01, (last_r != len_r) ? 1 : 0);
      mdl_last = win;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
